// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with frame-synchronous updates.
// Optional blink support is compiled in when SSD_BLINK_EN is defined.
module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_BITS    = 18,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic [3:0]              bright,
    input  logic                    load,
    output logic                    busy,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic [2:0]              scan_idx,
    output logic                    frame_tick
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [SCAN_BITS-1:0]    slot_cnt_q, slot_cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic                    frame_tick_q;
    logic                    busy_q, busy_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d, pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                    slot_max, wrap;
    logic [3:0]              cur_hex;
    logic                    cur_blank, cur_dp, blink_dark, anode_on;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b0000001;
            4'h1: hex_to_seg = 7'b1001111;
            4'h2: hex_to_seg = 7'b0010010;
            4'h3: hex_to_seg = 7'b0000110;
            4'h4: hex_to_seg = 7'b1001100;
            4'h5: hex_to_seg = 7'b0100100;
            4'h6: hex_to_seg = 7'b0100000;
            4'h7: hex_to_seg = 7'b0001111;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0000100;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b1100000;
            4'hC: hex_to_seg = 7'b0110001;
            4'hD: hex_to_seg = 7'b1000010;
            4'hE: hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    assign slot_max = &slot_cnt_q;
    assign wrap     = slot_max && (idx_q == LAST_IDX);

    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (slot_max) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end
    end

    // A load landing on the wrap edge bypasses pending and commits at once.
    always_comb begin
        act_digits_d  = act_digits_q;
        act_blank_d   = act_blank_q;
        act_dp_d      = act_dp_q;
        pend_digits_d = pend_digits_q;
        pend_blank_d  = pend_blank_q;
        pend_dp_d     = pend_dp_q;
        busy_d        = busy_q;
        if (load) begin
            pend_digits_d = digits_in;
            pend_blank_d  = blank_in;
            pend_dp_d     = dp_in;
        end
        if (wrap) begin
            busy_d       = 1'b0;
            act_digits_d = load ? digits_in : pend_digits_q;
            act_blank_d  = load ? blank_in  : pend_blank_q;
            act_dp_d     = load ? dp_in     : pend_dp_q;
        end else if (load) begin
            busy_d = 1'b1;
        end
    end

`ifdef SSD_BLINK_EN
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] act_blink_q, pend_blink_q;
    logic [BC_W-1:0]       blink_cnt_q;
    logic                  blink_phase_q;
    logic                  cur_blink;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_blink_q   <= '0;
            pend_blink_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            if (load) begin
                pend_blink_q <= blink_in;
            end
            if (wrap) begin
                act_blink_q <= load ? blink_in : pend_blink_q;
                if (blink_cnt_q == BC_LAST) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) cur_blink = act_blink_q[i];
        end
    end

    assign blink_dark = cur_blink && blink_phase_q;
`else
    logic blink_unused;
    assign blink_unused = ^blink_in;
    assign blink_dark   = 1'b0;
`endif

    assign anode_on = (slot_cnt_q[SCAN_BITS-1 -: 4] <= bright);

    always_comb begin
        cur_hex   = 4'h0;
        cur_blank = 1'b1;
        cur_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_hex   = act_digits_q[4*i +: 4];
                cur_blank = act_blank_q[i];
                cur_dp    = act_dp_q[i];
            end
        end
        an_d  = '1;
        seg_d = 8'hFF;
        if (anode_on && !cur_blank && !blink_dark) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == 3'(i)) an_d[i] = 1'b0;
            end
            seg_d = {hex_to_seg(cur_hex), ~cur_dp};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_q    <= '0;
            idx_q         <= 3'd0;
            frame_tick_q  <= 1'b0;
            busy_q        <= 1'b0;
            an_q          <= '1;
            seg_q         <= 8'hFF;
            act_digits_q  <= '0;
            act_blank_q   <= '1;
            act_dp_q      <= '0;
            pend_digits_q <= '0;
            pend_blank_q  <= '1;
            pend_dp_q     <= '0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            frame_tick_q  <= wrap;
            busy_q        <= busy_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            act_digits_q  <= act_digits_d;
            act_blank_q   <= act_blank_d;
            act_dp_q      <= act_dp_d;
            pend_digits_q <= pend_digits_d;
            pend_blank_q  <= pend_blank_d;
            pend_dp_q     <= pend_dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign busy       = busy_q;
    assign scan_idx   = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with a 4-digit, 16-cycle-slot, 64-cycle frame.
// Expected display per frame comes from a hand-kept copy of the committed digit data.
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int SB = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_in = '0;
    logic [3:0]  bright = 4'd15;
    logic        load = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [2:0]  scan_idx;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [15:0] shown_digits;
    logic [3:0]  shown_blank, shown_dp, shown_blink;
    int          wraps;
    logic [7:0]  first_seg [4];

    ssd_scan_driver #(.NUM_DIGITS(ND), .SCAN_BITS(SB), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .blank_in(blank_in),
        .dp_in(dp_in), .blink_in(blink_in), .bright(bright), .load(load),
        .busy(busy), .an(an), .seg(seg), .scan_idx(scan_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
        endcase
    endfunction

    task automatic model_reset();
        shown_digits = '0;
        shown_blank  = 4'hF;
        shown_dp     = '0;
        shown_blink  = '0;
        wraps        = 0;
    endtask

    task automatic wait_tick();
        int seen;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1;
        end
        check("tick_seen", 32'(seen), 32'd1);
        wraps++;
    endtask

    // Starts on the negedge where frame_tick is high, ends on the next one.
    task automatic do_frame(input int load_k, input logic [15:0] nd, input logic [3:0] nb,
                            input logic [3:0] ndp, input logic [3:0] nbl);
        logic       phase;
        int         d, s;
        logic       lit;
        logic [3:0] ea;
        logic [7:0] es;
        phase = ((wraps / BF) % 2) == 1;
`ifndef SSD_BLINK_EN
        phase = 1'b0;
`endif
        if (load_k == 0) begin
            digits_in = nd; blank_in = nb; dp_in = ndp; blink_in = nbl; load = 1'b1;
        end
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == load_k + 1) load = 1'b0;
            d   = (k - 1) / 16;
            s   = (k - 1) % 16;
            lit = !shown_blank[d] && !(shown_blink[d] && phase) && (s <= int'(bright));
            ea  = lit ? ~(4'b0001 << d) : 4'hF;
            es  = lit ? {hex7(shown_digits[4*d +: 4]), ~shown_dp[d]} : 8'hFF;
            check("an", 32'(an), 32'(ea));
            check("seg", 32'(seg), 32'(es));
            check("scan_idx", 32'(scan_idx), 32'((k / 16) % 4));
            check("frame_tick", 32'(frame_tick), (k == 64) ? 32'd1 : 32'd0);
            check("busy", 32'(busy), (load_k >= 0 && k > load_k && k < 64) ? 32'd1 : 32'd0);
            if (s == 0) first_seg[d] = seg;
            if (k == load_k) begin
                digits_in = nd; blank_in = nb; dp_in = ndp; blink_in = nbl; load = 1'b1;
            end
        end
        wraps++;
        if (load_k >= 0) begin
            shown_digits = nd; shown_blank = nb; shown_dp = ndp;
`ifdef SSD_BLINK_EN
            shown_blink = nbl;
`else
            shown_blink = 4'h0;
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(scan_idx), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        reset = 1'b1;

        // Dark after reset, 64-cycle frame period.
        wait_tick();
        do_frame(-1, '0, '0, '0, '0);
        do_frame(-1, '0, '0, '0, '0);

        // Load at frame start, shown one frame later.
        bright = 4'd15;
        do_frame(0, 16'h1A2F, 4'b0000, 4'b0001, 4'b0000);
        do_frame(-1, '0, '0, '0, '0);
        check("d0_seg", 32'(first_seg[0]), 32'h70);
        check("d1_seg", 32'(first_seg[1]), 32'h25);
        check("d2_seg", 32'(first_seg[2]), 32'h11);
        check("d3_seg", 32'(first_seg[3]), 32'h9F);

        // Mid-frame load with digit3 blanked.
        do_frame(16, 16'h4B0C, 4'b1000, 4'b0010, 4'b0000);
        do_frame(-1, '0, '0, '0, '0);

        // Reduced brightness.
        bright = 4'd3;
        do_frame(-1, '0, '0, '0, '0);
        bright = 4'd0;
        do_frame(-1, '0, '0, '0, '0);
        bright = 4'd15;

        // Load on the wrap edge commits directly, then blink over several frames.
        do_frame(63, 16'h3E59, 4'b0000, 4'b1000, 4'b0100);
        for (int f = 0; f < 5; f++) do_frame(-1, '0, '0, '0, '0);

        // Reset mid-frame with an update pending.
        digits_in = 16'h7777; blank_in = 4'b0000; dp_in = 4'b0000; blink_in = 4'b0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        repeat (31) @(negedge clk);
        check("pre_rst_idx", 32'(scan_idx), 32'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'hFF);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_idx", 32'(scan_idx), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_tick();
        do_frame(-1, '0, '0, '0, '0);
        do_frame(-1, '0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
